// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 pixel capture block: FSM state encoding,
// default frame geometry and the frame-buffer address width.
// ---------------------------------------------------------------------------
package ov7670_pkg;

    localparam int ADDR_W      = 17;
    localparam int DEF_H_PIX   = 320;
    localparam int DEF_V_LINES = 240;

    typedef enum logic [1:0] {
        S_WAIT_VS    = 2'd0,
        S_WAIT_START = 2'd1,
        S_ACTIVE     = 2'd2
    } state_t;

endpackage

// File: rtl/ov7670_byte_pair.sv
// ---------------------------------------------------------------------------
// ov7670_byte_pair
// Pairs consecutive camera bytes into one RGB565 pixel. The first byte of a
// pair is held as the high byte; the second byte completes the pixel.
//
// Ports
//   clk          : camera pixel clock
//   reset        : synchronous active-high reset
//   i_clear      : synchronous clear of the byte phase (line/frame boundary)
//   i_valid      : current byte is a valid line byte
//   i_data[7:0]  : camera byte
//   o_pix_valid  : current byte completes a pixel
//   o_pixel[15:0]: {held high byte, current byte}, valid with o_pix_valid
// ---------------------------------------------------------------------------
module ov7670_byte_pair (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_pix_valid,
    output logic [15:0] o_pixel
);

    logic       r_phase;
    logic [7:0] r_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_hi    <= 8'd0;
        end else if (i_clear) begin
            // a pending high byte with no partner is simply forgotten
            r_phase <= 1'b0;
        end else if (i_valid) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_hi <= i_data;
            end
        end
    end

    assign o_pix_valid = i_valid & r_phase;
    assign o_pixel     = {r_hi, i_data};

endmodule

// File: rtl/ov7670_pixel_capture.sv
// ---------------------------------------------------------------------------
// ov7670_pixel_capture
// Captures RGB565 frames from an OV7670 camera into a linear frame buffer
// (address y*H_PIX + x). Frames start on a vsync high->low sequence; a frame
// whose start sees freeze=1 is not written. H_PIX*V_LINES must not exceed
// 131072 (17-bit address space).
//
// Optional feature macro: OV_FRAME_STATS_EN adds frame_cnt / line_cnt.
//
// Ports
//   clk          : camera pixel clock, all logic on rising edge
//   reset        : synchronous active-high reset
//   href         : line valid
//   vsync        : frame sync, high between frames
//   data[7:0]    : camera byte, high byte of each pixel first
//   freeze       : sampled at frame start; 1 suppresses the whole frame
//   we           : one-cycle write pulse per stored pixel
//   wAddr[16:0]  : write address
//   wData[15:0]  : RGB565 pixel
//   frame_done   : one-cycle pulse at end of each captured frame
//   capturing    : high while a non-frozen frame is active
//   frame_cnt    : (OV_FRAME_STATS_EN) captured frames, wrapping
//   line_cnt     : (OV_FRAME_STATS_EN) lines in last captured frame, sat 511
//
// state        | meaning
// S_WAIT_VS    | waiting for vsync high (after reset or abort)
// S_WAIT_START | vsync high, waiting for it to drop to start a frame
// S_ACTIVE     | frame in progress, lines and pixels captured
// ---------------------------------------------------------------------------
module ov7670_pixel_capture
    import ov7670_pkg::*;
#(
    parameter int H_PIX   = DEF_H_PIX,
    parameter int V_LINES = DEF_V_LINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        data,
    input  logic              freeze,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              capturing
`ifdef OV_FRAME_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [8:0]        line_cnt
`endif
);

    localparam int PIX_W  = $clog2(H_PIX + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_line_base;
    logic [15:0]         r_wdata;
    logic                r_frame_done;
    logic                r_capturing;
    logic                r_frozen;
    logic                r_href_d;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic [LINE_W-1:0]   r_line_cnt;

    logic                w_active;
    logic                w_href_fall;
    logic                w_byte_valid;
    logic                w_clear;
    logic                w_pix_valid;
    logic [15:0]         w_pixel;
    logic                w_pix_ok;
    logic                w_line_ok;

    assign w_active     = (r_state == S_ACTIVE);
    assign w_href_fall  = r_href_d & ~href;
    assign w_byte_valid = w_active & href & ~vsync;
    // phase is held clear outside a frame so every frame starts on a high byte
    assign w_clear      = ~w_active | w_href_fall;
    assign w_pix_ok     = (r_pix_cnt < PIX_W'(H_PIX));
    assign w_line_ok    = (r_line_cnt < LINE_W'(V_LINES));

    ov7670_byte_pair u_byte_pair (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_valid     (w_byte_valid),
        .i_data      (data),
        .o_pix_valid (w_pix_valid),
        .o_pixel     (w_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT_VS;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_line_base  <= '0;
            r_wdata      <= 16'd0;
            r_frame_done <= 1'b0;
            r_capturing  <= 1'b0;
            r_frozen     <= 1'b0;
            r_href_d     <= 1'b0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
        end else begin
            r_href_d     <= href;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_we) begin
                r_waddr <= r_waddr + ADDR_W'(1);
            end
            case (r_state)
                S_WAIT_VS: begin
                    if (vsync) begin
                        r_state <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (!vsync) begin
                        r_state     <= S_ACTIVE;
                        r_waddr     <= '0;
                        r_line_base <= '0;
                        r_pix_cnt   <= '0;
                        r_line_cnt  <= '0;
                        r_frozen    <= freeze;
                        r_capturing <= ~freeze;
                    end
                end
                S_ACTIVE: begin
                    if (vsync) begin
                        r_state      <= S_WAIT_START;
                        r_capturing  <= 1'b0;
                        r_frame_done <= ~r_frozen;
                    end else begin
                        if (w_pix_valid && w_pix_ok) begin
                            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                            if (w_line_ok && !r_frozen) begin
                                r_we    <= 1'b1;
                                r_wdata <= w_pixel;
                            end
                        end
                        if (w_href_fall) begin
                            r_pix_cnt <= '0;
                            // Re-base on the next row so a short line leaves
                            // its unwritten tail instead of shifting later rows.
                            if (w_line_ok) begin
                                r_line_cnt  <= r_line_cnt + LINE_W'(1);
                                r_line_base <= r_line_base + ADDR_W'(H_PIX);
                                r_waddr     <= r_line_base + ADDR_W'(H_PIX);
                            end
                        end
                    end
                end
                default: r_state <= S_WAIT_VS;
            endcase
        end
    end

    assign we         = r_we;
    assign wAddr      = r_waddr;
    assign wData      = r_wdata;
    assign frame_done = r_frame_done;
    assign capturing  = r_capturing;

`ifdef OV_FRAME_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [8:0]  r_lines_seen;
    logic [8:0]  r_line_cnt_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt     <= 16'd0;
            r_lines_seen    <= 9'd0;
            r_line_cnt_last <= 9'd0;
        end else if (r_state == S_WAIT_START && !vsync) begin
            r_lines_seen <= 9'd0;
        end else if (w_active && vsync) begin
            if (!r_frozen) begin
                r_frame_cnt     <= r_frame_cnt + 16'd1;
                r_line_cnt_last <= r_lines_seen;
            end
        end else if (w_active && w_href_fall && r_lines_seen != 9'd511) begin
            r_lines_seen <= r_lines_seen + 9'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign line_cnt  = r_line_cnt_last;
`else
    // statistics counters are not built
`endif

endmodule

// File: doc/ov7670_pixel_capture.md
OV7670_PIXEL_CAPTURE -- requirements
Module: ov7670_pixel_capture

Interface
REQ-001 Parameter H_PIX, default 320: pixels per line stored.
REQ-002 Parameter V_LINES, default 240: lines per frame stored.
REQ-003 Port clk  input  1: sole clock, camera pixel clock; all logic on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port href  input  1: camera line-valid, high while line bytes present.
REQ-006 Port vsync  input  1: camera frame sync, high between frames.
REQ-007 Port data  input  8: camera byte, RGB565 high byte first.
REQ-008 Port freeze  input  1: level; when high at frame start, that frame is not written.
REQ-009 Port we  output  1: frame-buffer write enable, one-cycle pulse per pixel.
REQ-010 Port wAddr  output  17: frame-buffer write address, linear y*H_PIX+x.
REQ-011 Port wData  output  16: RGB565 pixel {first byte, second byte}.
REQ-012 Port frame_done  output  1: one-cycle pulse at end of each captured (non-frozen) frame.
REQ-013 Port capturing  output  1: high while in S_ACTIVE and not frozen.

Function
REQ-014 FSM states SHALL be S_WAIT_VS (wait vsync=1), S_WAIT_START (wait vsync=0), S_ACTIVE.
REQ-015 S_WAIT_VS -> S_WAIT_START when vsync=1; S_WAIT_START -> S_ACTIVE when vsync=0.
REQ-016 On S_WAIT_START -> S_ACTIVE: wAddr, byte phase, pixel and line counters cleared; freeze sampled into frozen flag.
REQ-017 S_ACTIVE -> S_WAIT_START when vsync=1; frame_done pulses that same cycle if frozen=0.
REQ-018 In S_ACTIVE with href=1, byte phase toggles each cycle; phase 0 stores data as high byte.
REQ-019 Phase-1 byte completes pixel; we=1 next cycle with wData={high,data} and wAddr current, if frozen=0 and pixel index < H_PIX*V_LINES.
REQ-020 wAddr SHALL increment by 1 the cycle after each we pulse; it SHALL not advance for suppressed writes.
REQ-021 Pixels beyond H_PIX in a line SHALL be dropped (no we, no address advance); pixel counter saturates at H_PIX.
REQ-022 href falling edge SHALL reset byte phase and pixel counter, increment line counter; odd trailing byte discarded.
REQ-023 Lines beyond V_LINES SHALL be dropped; short lines or frames leave remaining buffer locations unwritten.
REQ-024 vsync=1 mid-line SHALL abort the line and take REQ-017 transition.
REQ-025 freeze changes inside S_ACTIVE SHALL have no effect until next frame start.
REQ-026 Address arithmetic SHALL be 17-bit unsigned; H_PIX*V_LINES SHALL not exceed 131072.

Reset
REQ-027 On reset: state S_WAIT_VS, we=0, wAddr=0, wData=0, frame_done=0, capturing=0, counters and phase 0, frozen=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; capture resumes only after a full vsync high->low sequence.

Configuration
REQ-029 Macro OV_FRAME_STATS_EN SHALL, when defined, add outputs frame_cnt (16, wraps at 65535, increments with frame_done) and line_cnt (9, lines seen in last completed frame, saturating at 511).
REQ-030 Without OV_FRAME_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package ov7670_pkg SHALL hold the FSM state enum, default H_PIX/V_LINES, and address width constant 17.
REQ-032 Sub-module ov7670_byte_pair (phase toggle plus RGB565 assembly) is natural; the FSM and counters stay in top.

Verification
REQ-033 Reset, then vsync 1->0, 2 lines of 640 bytes, H_PIX=320 V_LINES=2 -> 640 we pulses, wAddr 0..639, frame_done once on next vsync rise.
REQ-034 Bytes 0xF8,0x1F -> wData=0xF81F with we exactly one cycle after byte 0x1F.
REQ-035 freeze=1 at frame start, toggled to 0 mid-frame -> zero we pulses, no frame_done, capturing=0 whole frame.
REQ-036 Line of 641 bytes then 700-byte line (H_PIX=320) -> 320 writes each; odd byte dropped; next line starts at wAddr 320.
REQ-037 reset asserted mid-line at wAddr 100 -> outputs at reset values next cycle; no we until new vsync high->low, then wAddr restarts at 0.
REQ-038 With OV_FRAME_STATS_EN, three frames of 240 lines -> frame_cnt=3, line_cnt=240.
